// File: rtl/fetch_pc_ctrl.sv
// Fetch sequencer: steers the external PC register, issues req/ack instruction fetches and
// buffers {pc,instr} pairs in a 2-entry FIFO. Optional feature macro: FETCH_MISALIGN_TRAP_EN.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        pc_stall_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        misalign_o,
    output logic [31:0] misalign_addr_o
);

    typedef enum logic [1:0] {BOOT, FETCH, WAIT, DROP} state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] addr_r;
    logic [31:0] fifo_pc_r    [2];
    logic [31:0] fifo_instr_r [2];
    logic        wr_ptr_r, rd_ptr_r;
    logic [1:0]  count_r;
    logic        req_s, ack_s, redir_s, push_s, pop_s;
    logic [31:0] addr_s, target_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        mis_s, mis_r;
    logic [31:0] mis_addr_r;

    // Misaligned redirect targets divert to the trap vector
    always_comb begin
        mis_s    = (redirect_pc_i[1:0] != 2'b00);
        target_s = mis_s ? TRAP_VECTOR : redirect_pc_i;
    end

    assign misalign_o      = mis_r & ~rst;
    assign misalign_addr_o = rst ? 32'h0000_0000 : mis_addr_r;
`else
    assign target_s        = redirect_pc_i & 32'hFFFF_FFFC;
    assign misalign_o      = 1'b0;
    assign misalign_addr_o = 32'h0000_0000;
`endif

    // Request generation: an outstanding fetch keeps its original address until acked
    always_comb begin
        req_s  = 1'b0;
        addr_s = pc_i;
        if (rst) begin
            req_s = 1'b0;
        end else begin
            case (state_r)
                FETCH:       req_s = (count_r != 2'd2);
                WAIT, DROP: begin
                    req_s  = 1'b1;
                    addr_s = addr_r;
                end
                default:     req_s = 1'b0;
            endcase
        end
    end

    assign ack_s   = imem_ack_i & req_s;
    assign redir_s = redirect_i & ~rst & (state_r != BOOT);
    assign push_s  = ack_s & ~redir_s & (state_r != DROP);
    assign pop_s   = instr_valid_o & instr_ready_i;

    // PC register control: redirect beats advance, anything else holds
    always_comb begin
        pc_stall_o = 1'b1;
        pc_next_o  = pc_i;
        if (rst || state_r == BOOT) begin
            pc_stall_o = 1'b0;
            pc_next_o  = RESET_VECTOR;
        end else if (redir_s) begin
            pc_stall_o = 1'b0;
            pc_next_o  = target_s;
        end else if (push_s) begin
            pc_stall_o = 1'b0;
            pc_next_o  = pc_i + 32'd4;
        end else begin
            pc_stall_o = 1'b1;
            pc_next_o  = pc_i;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            BOOT:  state_nxt_s = FETCH;
            FETCH: state_nxt_s = (req_s && !ack_s) ? (redir_s ? DROP : WAIT) : FETCH;
            WAIT:  state_nxt_s = ack_s ? FETCH : (redir_s ? DROP : WAIT);
            DROP:  state_nxt_s = ack_s ? FETCH : DROP;
            default: state_nxt_s = BOOT;
        endcase
    end

    // State, outstanding address, FIFO and misalign registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= BOOT;
            addr_r   <= 32'h0000_0000;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_r      <= 1'b0;
            mis_addr_r <= 32'h0000_0000;
`endif
        end else begin
            state_r <= state_nxt_s;
            if (state_r == FETCH && req_s) begin
                addr_r <= pc_i;
            end
            if (redir_s) begin
                wr_ptr_r <= 1'b0;
                rd_ptr_r <= 1'b0;
                count_r  <= 2'd0;
            end else begin
                if (push_s) begin
                    fifo_pc_r[wr_ptr_r]    <= addr_s;
                    fifo_instr_r[wr_ptr_r] <= imem_rdata_i;
                    wr_ptr_r               <= ~wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= ~rd_ptr_r;
                end
                count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_r <= redir_s & mis_s;
            if (redir_s && mis_s) begin
                mis_addr_r <= redirect_pc_i;
            end
`endif
        end
    end

    assign imem_req_o    = req_s;
    assign imem_addr_o   = addr_s;
    assign instr_valid_o = (count_r != 2'd0) & ~rst;
    assign instr_o       = fifo_instr_r[rd_ptr_r];
    assign instr_pc_o    = fifo_pc_r[rd_ptr_r];

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios plus randomized traffic
// against a queue-based reference model that also plays the external PC register.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RV = 32'h0000_0100;
    localparam logic [31:0] TV = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst, imem_ack, instr_ready, redirect;
    logic [31:0] pc_i, imem_rdata, redirect_pc;
    logic [31:0] pc_next, imem_addr, instr, instr_pc, misalign_addr;
    logic        pc_stall, imem_req, instr_valid, misalign;

    int vectors = 0;
    int miscompares = 0;

    fetch_pc_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_next_o(pc_next), .pc_stall_o(pc_stall),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack),
        .imem_rdata_i(imem_rdata), .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instr_o(instr), .instr_pc_o(instr_pc), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .misalign_o(misalign), .misalign_addr_o(misalign_addr)
    );

    always #5 clk = ~clk;

    // Reference model: m_phase 0 = no fetch outstanding, 1 = waiting, 2 = dropping
    logic [31:0] q_pc[$], q_in[$];
    logic        m_boot, m_mis;
    int          m_phase;
    logic [31:0] m_pc = 32'h0, m_out_addr, m_mis_addr;
    logic        e_req, e_stall, e_valid, e_mis, e_ack, e_redir, e_push;
    logic [31:0] e_addr, e_next, e_ipc, e_instr, e_mis_addr, e_tgt;

    function automatic logic [31:0] tgt(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return (t % 4 != 0) ? TV : t;
`else
        return t - (t % 4);
`endif
    endfunction

    task automatic eval_model();
        pc_i    = m_pc;
        e_tgt   = tgt(redirect_pc);
        e_valid = !rst && q_pc.size() != 0;
        e_ipc   = e_valid ? q_pc[0] : 32'h0;
        e_instr = e_valid ? q_in[0] : 32'h0;
        e_mis      = rst ? 1'b0 : m_mis;
        e_mis_addr = rst ? 32'h0 : m_mis_addr;
        e_redir = 1'b0; e_ack = 1'b0; e_push = 1'b0;
        e_req   = 1'b0; e_addr = m_pc;
        if (rst || m_boot) begin
            e_stall = 1'b0; e_next = RV;
        end else begin
            e_req  = (m_phase != 0) || (q_pc.size() < 2);
            e_addr = (m_phase != 0) ? m_out_addr : m_pc;
            e_ack  = e_req && imem_ack;
            e_redir = redirect;
            e_push = e_ack && !e_redir && m_phase != 2;
            if (e_redir) begin
                e_stall = 1'b0; e_next = e_tgt;
            end else if (e_push) begin
                e_stall = 1'b0; e_next = m_pc + 32'd4;
            end else begin
                e_stall = 1'b1; e_next = m_pc;
            end
        end
        #2;
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_boot = 1'b1; m_phase = 0; q_pc.delete(); q_in.delete();
            m_mis = 1'b0; m_mis_addr = 32'h0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_mis = 1'b0;
        end else begin
            if (e_redir) begin
                q_pc.delete(); q_in.delete();
            end else begin
                if (e_valid && instr_ready) begin
                    void'(q_pc.pop_front()); void'(q_in.pop_front());
                end
                if (e_push) begin
                    q_pc.push_back(e_addr); q_in.push_back(imem_rdata);
                end
            end
            if (m_phase == 0 && e_req && !e_ack) m_out_addr = m_pc;
            if (e_ack) m_phase = 0;
            else if (e_redir && e_req) m_phase = 2;
            else if (m_phase == 0 && e_req) m_phase = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_mis = e_redir && (redirect_pc % 4 != 0);
            if (m_mis) m_mis_addr = redirect_pc;
`endif
        end
        if (!e_stall) m_pc = e_next;
        #1;
    endtask

    task automatic set_in(input logic r, input logic a, input logic rdy, input logic rd,
                          input logic [31:0] rpc, input logic [31:0] data);
        rst = r; imem_ack = a; instr_ready = rdy; redirect = rd;
        redirect_pc = rpc; imem_rdata = data;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(i < 2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            eval_model(); advance();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            eval_model();
            if (i == 1) begin
                vectors++; if (pc_stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %h want 0", pc_stall); end
                vectors++; if (pc_next !== RV) begin miscompares++; $display("FAIL rst_pc_next got %h want %h", pc_next, RV); end
                vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %h want 0", imem_req); end
                vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %h want 0", instr_valid); end
                vectors++; if (misalign !== 1'b0 || misalign_addr !== 32'h0) begin miscompares++; $display("FAIL rst_misalign got %h/%h want 0/0", misalign, misalign_addr); end
            end
            advance();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 32'h0);
        eval_model();
        vectors++; if (pc_stall !== 1'b0 || pc_next !== RV) begin miscompares++; $display("FAIL boot_pc got %h/%h want 0/%h", pc_stall, pc_next, RV); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL boot_req got %h want 0", imem_req); end
        advance();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        eval_model();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== RV) begin miscompares++; $display("FAIL first_fetch got %h/%h want 1/%h", imem_req, imem_addr, RV); end
        advance();
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hA000_0000 + k);
            eval_model();
            vectors++; if (imem_req !== 1'b1 || imem_addr !== RV + 4 * k) begin miscompares++; $display("FAIL stream_addr got %h/%h want 1/%h", imem_req, imem_addr, RV + 4 * k); end
            vectors++; if (pc_next !== RV + 4 * (k + 1) || pc_stall !== 1'b0) begin miscompares++; $display("FAIL stream_pc got %h want %h", pc_next, RV + 4 * (k + 1)); end
            if (k > 0) begin
                vectors++; if (instr_valid !== 1'b1 || instr_pc !== RV + 4 * (k - 1) || instr !== 32'hA000_0000 + k - 1) begin miscompares++; $display("FAIL stream_head got %h/%h/%h want 1/%h/%h", instr_valid, instr_pc, instr, RV + 4 * (k - 1), 32'hA000_0000 + k - 1); end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            set_in(1'b0, k < 3 || k > 4, k == 3 || k == 4, 1'b0, 32'h0, 32'hB000_0000 + k);
            eval_model();
            if (k == 2) begin
                vectors++; if (imem_req !== 1'b0 || pc_stall !== 1'b1 || pc_next !== 32'h108) begin miscompares++; $display("FAIL full_hold got %h/%h/%h want 0/1/108", imem_req, pc_stall, pc_next); end
            end
            if (k == 3) begin
                vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || imem_req !== 1'b0) begin miscompares++; $display("FAIL pop0 got %h/%h/%h want 1/100/0", instr_valid, instr_pc, imem_req); end
            end
            if (k == 4) begin
                vectors++; if (instr_pc !== 32'h104 || imem_req !== 1'b1 || imem_addr !== 32'h108) begin miscompares++; $display("FAIL pop1 got %h/%h/%h want 104/1/108", instr_pc, imem_req, imem_addr); end
            end
            if (k == 5) begin
                vectors++; if (imem_addr !== 32'h108 || instr_valid !== 1'b0 || pc_next !== 32'h10c) begin miscompares++; $display("FAIL wait_ack got %h/%h/%h want 108/0/10c", imem_addr, instr_valid, pc_next); end
            end
            if (k == 6) begin
                vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h108 || instr !== 32'hB000_0005) begin miscompares++; $display("FAIL resume_head got %h/%h/%h want 1/108/b0000005", instr_valid, instr_pc, instr); end
            end
            advance();
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_in(1'b0, c == 0 || c == 4, 1'b0, c == 2, 32'h200, (c == 4) ? 32'hDEAD_BEEF : 32'h1111_0000);
            eval_model();
            if (c == 2) begin
                vectors++; if (pc_stall !== 1'b0 || pc_next !== 32'h200 || imem_addr !== 32'h104) begin miscompares++; $display("FAIL redir_wait got %h/%h/%h want 0/200/104", pc_stall, pc_next, imem_addr); end
            end
            if (c == 3) begin
                vectors++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104 || pc_stall !== 1'b1) begin miscompares++; $display("FAIL drop_hold got %h/%h/%h/%h want 0/1/104/1", instr_valid, imem_req, imem_addr, pc_stall); end
            end
            if (c == 4) begin
                vectors++; if (pc_next !== 32'h200 || pc_stall !== 1'b1) begin miscompares++; $display("FAIL drop_ack got %h/%h want 200/1", pc_next, pc_stall); end
            end
            if (c == 5) begin
                vectors++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL after_drop got %h/%h/%h want 0/1/200", instr_valid, imem_req, imem_addr); end
            end
            advance();
        end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 32'h0BAD_0BAD);
        eval_model();
        vectors++; if (pc_next !== 32'h300 || pc_stall !== 1'b0) begin miscompares++; $display("FAIL redir_ack_pc got %h/%h want 300/0", pc_next, pc_stall); end
        advance();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        eval_model();
        vectors++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin miscompares++; $display("FAIL redir_ack_next got %h/%h/%h want 0/1/300", instr_valid, imem_req, imem_addr); end
        advance();
    endtask

    task automatic test_misalign();
        logic [31:0] want;
        do_reset();
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'h203, 32'h0);
        eval_model();
        advance();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        eval_model();
`ifdef FETCH_MISALIGN_TRAP_EN
        want = TV;
        vectors++; if (misalign !== 1'b1 || misalign_addr !== 32'h203) begin miscompares++; $display("FAIL misalign_pulse got %h/%h want 1/203", misalign, misalign_addr); end
`else
        want = 32'h200;
        vectors++; if (misalign !== 1'b0 || misalign_addr !== 32'h0) begin miscompares++; $display("FAIL misalign_tied got %h/%h want 0/0", misalign, misalign_addr); end
`endif
        vectors++; if (imem_addr !== want) begin miscompares++; $display("FAIL misalign_fetch got %h want %h", imem_addr, want); end
        advance();
        eval_model();
        vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL misalign_once got %h want 0", misalign); end
        advance();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_in(1'b0, c < 2, 1'b1, c == 0, 32'hFFFF_FFFC, 32'hC0DE_0000 + c);
            eval_model();
            if (c == 1) begin
                vectors++; if (imem_addr !== 32'hFFFF_FFFC || pc_next !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got %h/%h want fffffffc/0", imem_addr, pc_next); end
            end
            if (c == 2) begin
                vectors++; if (instr_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0 || instr !== 32'hC0DE_0001) begin miscompares++; $display("FAIL wrap_head got %h/%h/%h want fffffffc/0/c0de0001", instr_pc, imem_addr, instr); end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: t = $urandom_range(0, 255);
                1: t = 32'hFFFF_FF00 | $urandom_range(0, 255);
                default: t = $urandom;
            endcase
            set_in($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                   $urandom_range(0, 11) == 0, t, $urandom);
            eval_model();
            vectors++; if (imem_req !== e_req || (e_req && imem_addr !== e_addr)) begin miscompares++; $display("FAIL rnd_req n=%0d got %h/%h want %h/%h", n, imem_req, imem_addr, e_req, e_addr); end
            vectors++; if (pc_stall !== e_stall || pc_next !== e_next) begin miscompares++; $display("FAIL rnd_pc n=%0d got %h/%h want %h/%h", n, pc_stall, pc_next, e_stall, e_next); end
            vectors++; if (instr_valid !== e_valid || (e_valid && (instr_pc !== e_ipc || instr !== e_instr))) begin miscompares++; $display("FAIL rnd_head n=%0d got %h/%h/%h want %h/%h/%h", n, instr_valid, instr_pc, instr, e_valid, e_ipc, e_instr); end
            vectors++; if (misalign !== e_mis || misalign_addr !== e_mis_addr) begin miscompares++; $display("FAIL rnd_mis n=%0d got %h/%h want %h/%h", n, misalign, misalign_addr, e_mis, e_mis_addr); end
            advance();
        end
    endtask

    initial begin
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        pc_i = 32'h0;
        m_boot = 1'b1; m_phase = 0; m_mis = 1'b0; m_mis_addr = 32'h0; m_out_addr = 32'h0;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_ack();
        test_misalign();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
